mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 161 ++++++++++++++++
 tb/tb_mc_control.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
// Microcoded-style control unit for a small accumulator datapath.
// The opcode is decoded in EXEC. Multi-cycle instructions (MUL with latency > 1, IN) step
// through wait states. All outputs are Mealy: they depend on the state, the latched ImmSel
// and the live inputs.
module mc_control #(
    parameter int unsigned OPW     = 3,
    parameter int unsigned MUL_LAT = 3
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic [OPW-1:0] OpCode,
    input  logic           Cond,
    input  logic           InValid,
    output logic           RegWe,
    output logic [1:0]     WDataSel,
    output logic           ImmSel,
    output logic [2:0]     AluOp,
    output logic           PcWait,
    output logic           PcLoad,
    output logic           InAck,
    output logic           Busy
);

    typedef enum logic [1:0] {StExec, StMulWait, StInWait, StInRelease} state_e;
    typedef enum logic [2:0] {OpNop, OpAdd, OpAddi, OpSub, OpMul, OpMuli, OpBnz, OpIn} op_e;

    localparam logic [2:0] AluPassB = 3'b000;
    localparam logic [2:0] AluAdd   = 3'b001;
    localparam logic [2:0] AluSub   = 3'b010;
    localparam logic [2:0] AluMul   = 3'b011;

    localparam logic [1:0] SelAlu = 2'b00;
    localparam logic [1:0] SelIn  = 2'b10;

    // The issue cycle and the write-back cycle frame the wait cycles, so the counter
    // starts two below the latency.
    localparam int unsigned MulCntInitInt = (MUL_LAT > 1) ? (MUL_LAT - 2) : 0;
    localparam logic [3:0]  MulCntInit    = MulCntInitInt[3:0];

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       imm_q, imm_d;
    op_e        op;
    logic       hi_clear;

    // Decode: any set bit above bit 2 turns the opcode into a NOP.
    always_comb begin
        hi_clear = ((OpCode >> 3) == '0);
        op       = hi_clear ? op_e'(OpCode[2:0]) : OpNop;
    end

    // Next-state and Mealy output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        imm_d    = imm_q;
        RegWe    = 1'b0;
        WDataSel = SelAlu;
        ImmSel   = 1'b0;
        AluOp    = AluPassB;
        PcWait   = 1'b0;
        PcLoad   = 1'b0;
        InAck    = 1'b0;
        Busy     = (state_q != StExec);

        case (state_q)
            StExec: begin
                case (op)
                    OpAdd: begin
                        RegWe = 1'b1;
                        AluOp = AluAdd;
                    end
                    OpAddi: begin
                        RegWe  = 1'b1;
                        AluOp  = AluAdd;
                        ImmSel = 1'b1;
                    end
                    OpSub: begin
                        RegWe = 1'b1;
                        AluOp = AluSub;
                    end
                    OpMul, OpMuli: begin
                        AluOp  = AluMul;
                        ImmSel = (op == OpMuli);
                        if (MUL_LAT == 1) begin
                            RegWe = 1'b1;
                        end else begin
                            PcWait  = 1'b1;
                            imm_d   = (op == OpMuli);
                            cnt_d   = MulCntInit;
                            state_d = StMulWait;
                        end
                    end
                    OpBnz: begin
                        PcLoad = Cond;
                    end
                    OpIn: begin
                        PcWait  = 1'b1;
                        state_d = StInWait;
                    end
                    default: ;
                endcase
            end
            StMulWait: begin
                AluOp  = AluMul;
                ImmSel = imm_q;
                if (cnt_q != 4'd0) begin
                    PcWait = 1'b1;
                    cnt_d  = cnt_q - 4'd1;
                end else begin
                    RegWe   = 1'b1;
                    state_d = StExec;
                end
            end
            StInWait: begin
                PcWait = 1'b1;
                if (InValid) begin
                    RegWe    = 1'b1;
                    WDataSel = SelIn;
                    InAck    = 1'b1;
                    state_d  = StInRelease;
                end
            end
            StInRelease: begin
                // Hold until the producer drops InValid so one datum is consumed only once.
                if (InValid) begin
                    PcWait = 1'b1;
                end else begin
                    state_d = StExec;
                end
            end
            default: state_d = StExec;
        endcase

        // Reset masks every output so an aborted instruction never writes back.
        if (Reset) begin
            RegWe    = 1'b0;
            WDataSel = SelAlu;
            ImmSel   = 1'b0;
            AluOp    = AluPassB;
            PcWait   = 1'b1;
            PcLoad   = 1'b0;
            InAck    = 1'b0;
            Busy     = 1'b0;
        end
    end

    // State, counter and latched ImmSel registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= StExec;
            cnt_q   <= 4'd0;
            imm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            imm_q   <= imm_d;
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Bench for mc_control: four instances (OPW/MUL_LAT variants) share stimulus; directed
// scenarios use literal expectations, random traffic uses an instruction-level model.
module tb_mc_control;

    // Output vector layout: {Busy, InAck, PcLoad, PcWait, AluOp[2:0], ImmSel, WDataSel[1:0], RegWe}
    localparam logic [10:0] BBusy  = 11'h400;
    localparam logic [10:0] BInAck = 11'h200;
    localparam logic [10:0] BLoad  = 11'h100;
    localparam logic [10:0] BWait  = 11'h080;
    localparam logic [10:0] BMul   = 11'h030;
    localparam logic [10:0] BImm   = 11'h008;
    localparam logic [10:0] BSelIn = 11'h004;
    localparam logic [10:0] BWe    = 11'h001;

    typedef struct packed {
        int   mul;   // multiply cycles still to run, including the current one
        int   inph;  // 0 idle, 1 awaiting data, 2 awaiting InValid release
        logic imm;
    } mst_t;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Cond;
    logic       InValid;
    logic [2:0] OpCode;
    logic [4:0] op5;

    wire [10:0] v0, v1, v2, v3;
    logic [10:0] dv [4];
    int   lat_of [4] = '{3, 1, 4, 3};
    mst_t ms [4];
    int   checks = 0;
    int   passes = 0;

    always #5 Clock = ~Clock;

    mc_control #(.OPW(3), .MUL_LAT(3)) u_l3 (
        .Clock(Clock), .Reset(Reset), .OpCode(OpCode), .Cond(Cond), .InValid(InValid),
        .RegWe(v0[0]), .WDataSel(v0[2:1]), .ImmSel(v0[3]), .AluOp(v0[6:4]), .PcWait(v0[7]),
        .PcLoad(v0[8]), .InAck(v0[9]), .Busy(v0[10])
    );
    mc_control #(.OPW(3), .MUL_LAT(1)) u_l1 (
        .Clock(Clock), .Reset(Reset), .OpCode(OpCode), .Cond(Cond), .InValid(InValid),
        .RegWe(v1[0]), .WDataSel(v1[2:1]), .ImmSel(v1[3]), .AluOp(v1[6:4]), .PcWait(v1[7]),
        .PcLoad(v1[8]), .InAck(v1[9]), .Busy(v1[10])
    );
    mc_control #(.OPW(3), .MUL_LAT(4)) u_l4 (
        .Clock(Clock), .Reset(Reset), .OpCode(OpCode), .Cond(Cond), .InValid(InValid),
        .RegWe(v2[0]), .WDataSel(v2[2:1]), .ImmSel(v2[3]), .AluOp(v2[6:4]), .PcWait(v2[7]),
        .PcLoad(v2[8]), .InAck(v2[9]), .Busy(v2[10])
    );
    mc_control #(.OPW(5), .MUL_LAT(3)) u_w5 (
        .Clock(Clock), .Reset(Reset), .OpCode(op5), .Cond(Cond), .InValid(InValid),
        .RegWe(v3[0]), .WDataSel(v3[2:1]), .ImmSel(v3[3]), .AluOp(v3[6:4]), .PcWait(v3[7]),
        .PcLoad(v3[8]), .InAck(v3[9]), .Busy(v3[10])
    );

    always_comb begin
        dv[0] = v0;
        dv[1] = v1;
        dv[2] = v2;
        dv[3] = v3;
    end

    // Expected outputs for one cycle, from the instruction-level view of what is in flight.
    function automatic logic [10:0] ref_out(input int lat, input int opc, input logic cond,
                                            input logic inv, input logic rst, input mst_t s);
        logic [10:0] r;
        r = '0;
        if (rst) return BWait;
        if (s.mul > 0) begin
            r = BBusy | BMul | (s.imm ? BImm : 11'h0);
            r = r | ((s.mul == 1) ? BWe : BWait);
        end else if (s.inph == 1) begin
            r = BBusy | BWait | (inv ? (BWe | BSelIn | BInAck) : 11'h0);
        end else if (s.inph == 2) begin
            r = BBusy | (inv ? BWait : 11'h0);
        end else begin
            case (opc)
                1: r = BWe | 11'h010;
                2: r = BWe | 11'h010 | BImm;
                3: r = BWe | 11'h020;
                4, 5: r = BMul | ((opc == 5) ? BImm : 11'h0) | ((lat == 1) ? BWe : BWait);
                6: r = cond ? BLoad : 11'h0;
                7: r = BWait;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    function automatic mst_t model_step(input int lat, input int opc, input logic inv,
                                        input logic rst, input mst_t s);
        mst_t n;
        n = s;
        if (rst) begin
            n.mul = 0;
            n.inph = 0;
            n.imm = 1'b0;
        end else if (s.mul > 0) begin
            n.mul = s.mul - 1;
        end else if (s.inph == 1) begin
            if (inv) n.inph = 2;
        end else if (s.inph == 2) begin
            if (!inv) n.inph = 0;
        end else if ((opc == 4 || opc == 5) && lat > 1) begin
            n.mul = lat - 1;
            n.imm = (opc == 5);
        end else if (opc == 7) begin
            n.inph = 1;
        end
        return n;
    endfunction

    always @(posedge Clock) begin
        for (int i = 0; i < 4; i++) begin
            ms[i] <= model_step(lat_of[i], (i == 3) ? int'(op5) : int'(OpCode), InValid, Reset,
                                ms[i]);
        end
    end

    // Apply one cycle of stimulus just after the edge and return mid-cycle for sampling.
    task automatic drive(input logic [2:0] op, input logic [4:0] w, input logic c,
                         input logic inv, input logic rst);
        @(posedge Clock);
        #1;
        OpCode  = op;
        op5     = w;
        Cond    = c;
        InValid = inv;
        Reset   = rst;
        @(negedge Clock);
    endtask

    task automatic do_reset();
        drive(3'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dv[i] !== BWait) $display("FAIL reset_out[%0d]: got %h expected %h", i, dv[i], BWait);
            else passes++;
        end
    endtask

    task automatic test_mul_lat3();
        logic [10:0] exp [3];
        exp = '{BWait | BMul, BBusy | BWait | BMul, BBusy | BMul | BWe};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive((k == 0) ? 3'd4 : 3'd0, (k == 0) ? 5'd4 : 5'd0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (dv[0] !== exp[k]) $display("FAIL mul_lat3 cycle %0d: got %h expected %h", k, dv[0], exp[k]);
            else passes++;
        end
    endtask

    task automatic test_mul_lat1();
        do_reset();
        drive(3'd5, 5'd5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dv[1] !== (BMul | BImm | BWe)) $display("FAIL muli_lat1: got %h expected %h", dv[1], BMul | BImm | BWe);
        else passes++;
        drive(3'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dv[1] !== 11'h0) $display("FAIL muli_lat1_next: got %h expected %h", dv[1], 11'h0);
        else passes++;
    endtask

    task automatic test_in();
        int waits;
        int pulses;
        logic [10:0] exp;
        waits = 0;
        pulses = 0;
        do_reset();
        // issue, 5 idle cycles, 2 valid cycles, release
        for (int k = 0; k < 9; k++) begin
            drive((k == 0) ? 3'd7 : 3'd0, (k == 0) ? 5'd7 : 5'd0, 1'b0, (k == 6 || k == 7), 1'b0);
            if (k == 0) exp = BWait;
            else if (k == 6) exp = BBusy | BWait | BWe | BSelIn | BInAck;
            else if (k == 8) exp = BBusy;
            else exp = BBusy | BWait;
            if (dv[0][7]) waits++;
            if (dv[0][0]) pulses++;
            checks++;
            if (dv[0] !== exp) $display("FAIL in_seq cycle %0d: got %h expected %h", k, dv[0], exp);
            else passes++;
        end
        checks++;
        if (waits != 8) $display("FAIL in_pcwait_count: got %0d expected 8", waits);
        else passes++;
        checks++;
        if (pulses != 1) $display("FAIL in_regwe_count: got %0d expected 1", pulses);
        else passes++;
    endtask

    task automatic test_bnz();
        do_reset();
        drive(3'd6, 5'd6, 1'b1, 1'b0, 1'b0);
        checks++;
        if (dv[0] !== BLoad) $display("FAIL bnz_taken: got %h expected %h", dv[0], BLoad);
        else passes++;
        drive(3'd6, 5'd6, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dv[0] !== 11'h0) $display("FAIL bnz_not_taken: got %h expected %h", dv[0], 11'h0);
        else passes++;
    endtask

    task automatic test_mul_reset();
        logic [10:0] exp [6];
        int pulses;
        exp = '{BWait | BMul, BBusy | BWait | BMul, BWait, 11'h0, 11'h0, 11'h0};
        pulses = 0;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive((k == 0) ? 3'd4 : 3'd0, (k == 0) ? 5'd4 : 5'd0, 1'b0, 1'b0, (k == 2));
            if (dv[2][0]) pulses++;
            checks++;
            if (dv[2] !== exp[k]) $display("FAIL mul_reset cycle %0d: got %h expected %h", k, dv[2], exp[k]);
            else passes++;
        end
        checks++;
        if (pulses != 0) $display("FAIL mul_reset_regwe: got %0d expected 0", pulses);
        else passes++;
    endtask

    task automatic test_nop_wide();
        do_reset();
        drive(3'd0, 5'b01001, 1'b1, 1'b1, 1'b0);
        checks++;
        if (dv[3] !== 11'h0) $display("FAIL wide_nop_01001: got %h expected %h", dv[3], 11'h0);
        else passes++;
        drive(3'd0, 5'b11111, 1'b1, 1'b1, 1'b0);
        checks++;
        if (dv[3] !== 11'h0) $display("FAIL wide_nop_11111: got %h expected %h", dv[3], 11'h0);
        else passes++;
        drive(3'd0, 5'b00100, 1'b0, 1'b0, 1'b0);
        checks++;
        if (dv[3] !== (BWait | BMul)) $display("FAIL wide_mul: got %h expected %h", dv[3], BWait | BMul);
        else passes++;
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [4:0]  w;
        logic        inv;
        logic [10:0] exp;
        inv = 1'b0;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            op = 3'($urandom_range(0, 7));
            w  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : {2'b00, op};
            if ($urandom_range(0, 2) == 0) inv = ~inv;
            drive(op, w, 1'($urandom_range(0, 1)), inv, ($urandom_range(0, 29) == 0));
            for (int i = 0; i < 4; i++) begin
                exp = ref_out(lat_of[i], (i == 3) ? int'(op5) : int'(OpCode), Cond, InValid,
                              Reset, ms[i]);
                checks++;
                if (dv[i] !== exp)
                    $display("FAIL random n=%0d inst=%0d op=%0d: got %h expected %h",
                             n, i, (i == 3) ? int'(op5) : int'(OpCode), dv[i], exp);
                else passes++;
            end
        end
    endtask

    initial begin
        Reset   = 1'b1;
        OpCode  = 3'd0;
        op5     = 5'd0;
        Cond    = 1'b0;
        InValid = 1'b0;
        test_reset();
        test_mul_lat3();
        test_mul_lat1();
        test_in();
        test_bnz();
        test_mul_reset();
        test_nop_wide();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
